// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: compares the most recent PAT_W valid bits against a
// runtime-loadable pattern, pulses z for one cycle per match and keeps a saturating count.
module seq_pattern_detector #(
   parameter int              PAT_W    = 4,
   parameter logic [PAT_W-1:0] PAT_INIT = 4'b1010,
   parameter bit              OVERLAP  = 1'b1,
   parameter int              COUNT_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               x,
   input  logic               x_valid,
   input  logic               load,
   input  logic [PAT_W-1:0]   pattern_in,
   input  logic               count_clr,
   output logic               z,
   output logic [COUNT_W-1:0] match_count,
   output logic [PAT_W-1:0]   pattern
);

   localparam int                 FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_W);
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   logic [PAT_W-1:0]   patternQ, patternD;
   logic [PAT_W-1:0]   historyQ, historyD;
   logic [FILL_W-1:0]  fillQ, fillD;
   logic               zQ, zD;
   logic [COUNT_W-1:0] countQ, countD;

   logic [PAT_W-1:0]   shifted;
   logic [FILL_W-1:0]  fillInc;
   logic               matchHit;

   always_ff @(posedge clk) begin
      if (reset) begin
         patternQ <= PAT_INIT;
         historyQ <= '0;
         fillQ    <= '0;
         zQ       <= 1'b0;
         countQ   <= '0;
      end else begin
         patternQ <= patternD;
         historyQ <= historyD;
         fillQ    <= fillD;
         zQ       <= zD;
         countQ   <= countD;
      end
   end

   // Match is judged on the post-shift window, so the pulse lands exactly one clock after the last bit.
   always_comb begin
      shifted  = {historyQ[PAT_W-2:0], x};
      fillInc  = (fillQ == FILL_FULL) ? fillQ : fillQ + 1'b1;
      matchHit = 1'b0;
      patternD = patternQ;
      historyD = historyQ;
      fillD    = fillQ;
      if (load) begin
         patternD = pattern_in;
         historyD = '0;
         fillD    = '0;
      end else if (x_valid) begin
         historyD = shifted;
         fillD    = fillInc;
         matchHit = (fillInc == FILL_FULL) && (shifted == patternQ);
         if (matchHit && !OVERLAP) begin
            historyD = '0;
            fillD    = '0;
         end
      end
   end

   always_comb begin
      zD     = matchHit;
      countD = countQ;
      if (count_clr) begin
         countD = '0;
      end else if (matchHit && (countQ != COUNT_MAX)) begin
         countD = countQ + 1'b1;
      end
   end

   assign z           = zQ;
   assign match_count = countQ;
   assign pattern     = patternQ;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: three instances (overlap, non-overlap, 2-bit counter)
// checked through a scoreboard of expected z / count / pattern values.
module tb_seq_pattern_detector;

   logic       clk = 1'b0;
   logic       reset;
   logic       x;
   logic       xValid;
   logic       load;
   logic       countClr;
   logic [3:0] patternIn;
   logic [2:0] active;

   logic       zA, zB, zC;
   logic [7:0] cntA, cntB;
   logic [1:0] cntC;
   logic [3:0] patA, patB, patC;

   typedef struct {
      int         sel;
      logic       z;
      int         count;
      logic [3:0] pat;
      string      tag;
   } expT;

   expT scoreQ[$];
   int  assertCount = 0;
   int  failCount   = 0;

   always #5 clk = ~clk;

   seq_pattern_detector #(.PAT_W(4), .PAT_INIT(4'b1010), .OVERLAP(1'b1), .COUNT_W(8)) dutA (
      .clk(clk), .reset(reset), .x(x), .x_valid(xValid & active[0]), .load(load & active[0]),
      .pattern_in(patternIn), .count_clr(countClr & active[0]),
      .z(zA), .match_count(cntA), .pattern(patA)
   );

   seq_pattern_detector #(.PAT_W(4), .PAT_INIT(4'b1010), .OVERLAP(1'b0), .COUNT_W(8)) dutB (
      .clk(clk), .reset(reset), .x(x), .x_valid(xValid & active[1]), .load(load & active[1]),
      .pattern_in(patternIn), .count_clr(countClr & active[1]),
      .z(zB), .match_count(cntB), .pattern(patB)
   );

   seq_pattern_detector #(.PAT_W(4), .PAT_INIT(4'b1010), .OVERLAP(1'b1), .COUNT_W(2)) dutC (
      .clk(clk), .reset(reset), .x(x), .x_valid(xValid & active[2]), .load(load & active[2]),
      .pattern_in(patternIn), .count_clr(countClr & active[2]),
      .z(zC), .match_count(cntC), .pattern(patC)
   );

   // Pops every pending expectation and compares it with the addressed instance.
   task automatic checkOutput();
      expT        e;
      logic       obsZ;
      int         obsCnt;
      logic [3:0] obsPat;
      while (scoreQ.size() > 0) begin
         e = scoreQ.pop_front();
         case (e.sel)
            0:       begin obsZ = zA; obsCnt = int'(cntA); obsPat = patA; end
            1:       begin obsZ = zB; obsCnt = int'(cntB); obsPat = patB; end
            default: begin obsZ = zC; obsCnt = int'(cntC); obsPat = patC; end
         endcase
         assertCount++;
         assert (obsZ === e.z) else begin
            failCount++;
            $error("[TB] FAIL %s z observed=%0b expected=%0b", e.tag, obsZ, e.z);
         end
         assertCount++;
         assert (obsCnt === e.count) else begin
            failCount++;
            $error("[TB] FAIL %s match_count observed=%0d expected=%0d", e.tag, obsCnt, e.count);
         end
         assertCount++;
         assert (obsPat === e.pat) else begin
            failCount++;
            $error("[TB] FAIL %s pattern observed=%b expected=%b", e.tag, obsPat, e.pat);
         end
      end
   endtask

   task automatic pushExp(input string tag, input int sel, input logic expZ, input int expCnt,
                          input logic [3:0] expPat);
      expT e;
      e.sel   = sel;
      e.z     = expZ;
      e.count = expCnt;
      e.pat   = expPat;
      e.tag   = tag;
      scoreQ.push_back(e);
   endtask

   // Drives one cycle of inputs at the falling edge, then samples at the next falling edge.
   task automatic applyStimulus(input string tag, input int sel, input logic rst, input logic ld,
                                input logic [3:0] pin, input logic v, input logic xb,
                                input logic clr, input logic expZ, input int expCnt,
                                input logic [3:0] expPat);
      reset     = rst;
      load      = ld;
      patternIn = pin;
      xValid    = v;
      x         = xb;
      countClr  = clr;
      active    = 3'b001 << sel;
      pushExp(tag, sel, expZ, expCnt, expPat);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic sendBit(input string tag, input int sel, input logic xb, input logic expZ,
                          input int expCnt, input logic [3:0] expPat);
      applyStimulus(tag, sel, 1'b0, 1'b0, 4'b0000, 1'b1, xb, 1'b0, expZ, expCnt, expPat);
   endtask

   task automatic resetAll(input string tag);
      reset     = 1'b1;
      load      = 1'b0;
      patternIn = 4'b0000;
      xValid    = 1'b1;
      x         = 1'b1;
      countClr  = 1'b0;
      active    = 3'b111;
      pushExp({tag, "_A"}, 0, 1'b0, 0, 4'b1010);
      pushExp({tag, "_B"}, 1, 1'b0, 0, 4'b1010);
      pushExp({tag, "_C"}, 2, 1'b0, 0, 4'b1010);
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      logic s6[6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic z6[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int   c6[6]   = '{0, 0, 0, 1, 1, 2};
      logic zB10[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int   cB10[10] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2};
      logic zC10[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int   cC10[10] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3};
      logic b;

      resetAll("rst_init");
      resetAll("rst_init2");

      for (int i = 0; i < 6; i++)
         sendBit($sformatf("ovl_bit%0d", i + 1), 0, s6[i], z6[i], c6[i], 4'b1010);

      for (int i = 0; i < 10; i++) begin
         b = (i % 2 == 0);
         sendBit($sformatf("novl_bit%0d", i + 1), 1, b, zB10[i], cB10[i], 4'b1010);
      end

      resetAll("rst_gap");
      sendBit("gap_b1", 0, 1'b1, 1'b0, 0, 4'b1010);
      sendBit("gap_b2", 0, 1'b0, 1'b0, 0, 4'b1010);
      for (int i = 0; i < 3; i++)
         applyStimulus($sformatf("gap_idle%0d", i), 0, 1'b0, 1'b0, 4'b0000, 1'b0, i[0], 1'b0,
                       1'b0, 0, 4'b1010);
      sendBit("gap_b3", 0, 1'b1, 1'b0, 0, 4'b1010);
      sendBit("gap_b4", 0, 1'b0, 1'b1, 1, 4'b1010);

      applyStimulus("load_0110", 0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1, 4'b0110);
      sendBit("ld_b1", 0, 1'b0, 1'b0, 1, 4'b0110);
      sendBit("ld_b2", 0, 1'b1, 1'b0, 1, 4'b0110);
      sendBit("ld_b3", 0, 1'b1, 1'b0, 1, 4'b0110);
      sendBit("ld_b4", 0, 1'b0, 1'b1, 2, 4'b0110);
      for (int i = 0; i < 4; i++) begin
         b = (i % 2 == 0);
         sendBit($sformatf("ld_old%0d", i + 1), 0, b, 1'b0, 2, 4'b0110);
      end

      resetAll("rst_sat");
      for (int i = 0; i < 10; i++) begin
         b = (i % 2 == 0);
         sendBit($sformatf("sat_bit%0d", i + 1), 2, b, zC10[i], cC10[i], 4'b1010);
      end
      sendBit("sat_bit11", 2, 1'b1, 1'b0, 3, 4'b1010);
      applyStimulus("clr_on_match", 2, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 0, 4'b1010);
      sendBit("after_clr", 2, 1'b1, 1'b0, 0, 4'b1010);

      resetAll("rst_mid");
      sendBit("mid_b1", 0, 1'b1, 1'b0, 0, 4'b1010);
      sendBit("mid_b2", 0, 1'b0, 1'b0, 0, 4'b1010);
      sendBit("mid_b3", 0, 1'b1, 1'b0, 0, 4'b1010);
      applyStimulus("mid_reset", 0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b1010);
      sendBit("post_rst_0", 0, 1'b0, 1'b0, 0, 4'b1010);
      sendBit("post_rst_b1", 0, 1'b1, 1'b0, 0, 4'b1010);
      sendBit("post_rst_b2", 0, 1'b0, 1'b0, 0, 4'b1010);
      sendBit("post_rst_b3", 0, 1'b1, 1'b0, 0, 4'b1010);
      sendBit("post_rst_b4", 0, 1'b0, 1'b1, 1, 4'b1010);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
